// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command sequencer.
// Covers init-script entry codes, display opcodes, commAddr codes and the FSM states.
package lcd_pkg;

   typedef enum logic [1:0] {
      ENT_CMD = 2'd0,
      ENT_DAT = 2'd1,
      ENT_DLY = 2'd2,
      ENT_END = 2'd3
   } entryKindT;

   typedef struct packed {
      entryKindT  kind;
      logic [7:0] val;
   } romEntryT;

   localparam logic [7:0] OP_CASET = 8'h2A;
   localparam logic [7:0] OP_PASET = 8'h2B;
   localparam logic [7:0] OP_RAMWR = 8'h2C;

   localparam logic [2:0] ADDR_IDLE = 3'd0;
   localparam logic [2:0] ADDR_DATA = 3'd2;
   localparam logic [2:0] ADDR_CMD  = 3'd3;

   // Index of the first pixel byte, counted after the 11 window bytes.
   localparam logic [3:0] WIN_BYTES = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_FETCH,
      S_INIT_DELAY,
      S_WIN,
      S_PIX,
      S_FIN
   } stateT;

   function automatic logic [7:0] hiByte(input logic [15:0] v);
      return v[15:8];
   endfunction

   function automatic logic [7:0] loByte(input logic [15:0] v);
      return v[7:0];
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on initialisation script, synchronous read with one cycle of latency.
module lcd_init_rom
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   output romEntryT   entry
);

   // Software reset, settle delay, one parameter byte, end of script.
   always_ff @(posedge clk) begin
      case (addr)
         8'd0:    entry <= '{kind: ENT_CMD, val: 8'h01};
         8'd1:    entry <= '{kind: ENT_DLY, val: 8'd2};
         8'd2:    entry <= '{kind: ENT_DAT, val: 8'h55};
         default: entry <= '{kind: ENT_END, val: 8'h00};
      endcase
   end

endmodule

// File: rtl/lcd_sequencer.sv
// LCD write-path sequencer: runs the init script, then fills host rectangles
// with one colour through a shared byte engine driving commAddr/commData/wrEn.
module lcd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned COORD_W     = 9,
   parameter int unsigned WR_HI       = 2,
   parameter int unsigned WR_LO       = 2,
   parameter int unsigned DELAY_TICKS = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_init,
   input  logic               fill_req,
   input  logic [COORD_W-1:0] fill_x0,
   input  logic [COORD_W-1:0] fill_x1,
   input  logic [COORD_W-1:0] fill_y0,
   input  logic [COORD_W-1:0] fill_y1,
   input  logic [15:0]        fill_color,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               init_ok,
   output logic [7:0]         commData,
   output logic [2:0]         commAddr,
   output logic               wrEn
);

   localparam int unsigned PERIOD = WR_HI + WR_LO;
   localparam int unsigned PH_W   = $clog2(PERIOD);
   localparam int unsigned SPAN_W = COORD_W + 1;
   localparam int unsigned PIX_W  = 2 * COORD_W + 1;
   localparam int unsigned DLY_W  = 8 + $clog2(DELAY_TICKS + 1);

   stateT                state, stateNext;
   logic                 byteActive, byteFree, lastByteCycle;
   logic [PH_W-1:0]      phase;
   logic                 startByte;
   logic [2:0]           byteAddr;
   logic [7:0]           byteData;
   logic [COORD_W-1:0]   x0, x1, y0, y1;
   logic [15:0]          color;
   logic [PIX_W-1:0]     pixCnt, pixTotal;
   logic                 sentHi;
   logic [3:0]           seqIdx;
   logic [7:0]           romAddr;
   romEntryT             romEntry;
   logic                 romWait;
   logic [DLY_W-1:0]     delayCnt;
   logic [SPAN_W-1:0]    spanX, spanY;
   logic                 fillOk, acceptFill, rejectFill;

   lcd_init_rom u_rom (
      .clk   (clk),
      .addr  (romAddr),
      .entry (romEntry)
   );

   assign lastByteCycle = byteActive && (phase == PH_W'(PERIOD - 1));
   assign byteFree      = !byteActive || lastByteCycle;

   assign spanX      = SPAN_W'(fill_x1) - SPAN_W'(fill_x0) + SPAN_W'(1);
   assign spanY      = SPAN_W'(fill_y1) - SPAN_W'(fill_y0) + SPAN_W'(1);
   assign pixTotal   = PIX_W'(spanX) * PIX_W'(spanY);
   assign fillOk     = init_ok && (fill_x1 >= fill_x0) && (fill_y1 >= fill_y0);
   assign acceptFill = (state == S_IDLE) && !start_init && fill_req && fillOk;
   assign rejectFill = (state == S_IDLE) && !start_init && fill_req && !fillOk;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE: begin
            if (start_init)      stateNext = S_INIT_FETCH;
            else if (acceptFill) stateNext = S_WIN;
         end
         S_INIT_FETCH: begin
            if (!romWait && byteFree) begin
               case (romEntry.kind)
                  ENT_DLY: stateNext = S_INIT_DELAY;
                  ENT_END: stateNext = S_FIN;
                  default: stateNext = S_INIT_FETCH;
               endcase
            end
         end
         S_INIT_DELAY: if (delayCnt <= DLY_W'(1)) stateNext = S_INIT_FETCH;
         S_WIN:        if (byteFree && seqIdx == WIN_BYTES) stateNext = S_PIX;
         S_PIX:        if (lastByteCycle && !sentHi && pixCnt == PIX_W'(1)) stateNext = S_FIN;
         S_FIN:        stateNext = S_IDLE;
         default:      stateNext = S_IDLE;
      endcase
   end

   // Selects the byte launched into the engine this cycle, if any.
   always_comb begin
      startByte = 1'b0;
      byteAddr  = ADDR_DATA;
      byteData  = 8'h00;
      case (state)
         S_IDLE: begin
            if (acceptFill) begin
               startByte = 1'b1;
               byteAddr  = ADDR_CMD;
               byteData  = OP_CASET;
            end
         end
         S_INIT_FETCH: begin
            if (!romWait && byteFree &&
                (romEntry.kind == ENT_CMD || romEntry.kind == ENT_DAT)) begin
               startByte = 1'b1;
               byteAddr  = (romEntry.kind == ENT_CMD) ? ADDR_CMD : ADDR_DATA;
               byteData  = romEntry.val;
            end
         end
         S_WIN: begin
            if (byteFree) begin
               startByte = 1'b1;
               case (seqIdx)
                  4'd1:    byteData = hiByte(16'(x0));
                  4'd2:    byteData = loByte(16'(x0));
                  4'd3:    byteData = hiByte(16'(x1));
                  4'd4:    byteData = loByte(16'(x1));
                  4'd5:    begin byteAddr = ADDR_CMD; byteData = OP_PASET; end
                  4'd6:    byteData = hiByte(16'(y0));
                  4'd7:    byteData = loByte(16'(y0));
                  4'd8:    byteData = hiByte(16'(y1));
                  4'd9:    byteData = loByte(16'(y1));
                  4'd10:   begin byteAddr = ADDR_CMD; byteData = OP_RAMWR; end
                  default: byteData = hiByte(color);
               endcase
            end
         end
         S_PIX: begin
            if (lastByteCycle) begin
               if (sentHi) begin
                  startByte = 1'b1;
                  byteData  = loByte(color);
               end else if (pixCnt != PIX_W'(1)) begin
                  startByte = 1'b1;
                  byteData  = hiByte(color);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrEn       <= 1'b0;
         commAddr   <= ADDR_IDLE;
         commData   <= 8'h00;
         byteActive <= 1'b0;
         phase      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         init_ok    <= 1'b0;
         x0         <= '0;
         x1         <= '0;
         y0         <= '0;
         y1         <= '0;
         color      <= 16'h0000;
         pixCnt     <= '0;
         sentHi     <= 1'b0;
         seqIdx     <= 4'd0;
         romAddr    <= 8'd0;
         romWait    <= 1'b0;
         delayCnt   <= '0;
      end else begin
         // Byte engine: strobe high WR_HI cycles, low WR_LO, bus held throughout.
         if (startByte) begin
            wrEn       <= 1'b1;
            commAddr   <= byteAddr;
            commData   <= byteData;
            phase      <= '0;
            byteActive <= 1'b1;
         end else if (byteActive) begin
            phase <= phase + PH_W'(1);
            if (phase == PH_W'(WR_HI - 1)) wrEn <= 1'b0;
            if (lastByteCycle) begin
               byteActive <= 1'b0;
               commAddr   <= ADDR_IDLE;
               commData   <= 8'h00;
            end
         end

         busy <= (stateNext == S_INIT_FETCH) || (stateNext == S_INIT_DELAY) ||
                 (stateNext == S_WIN) || (stateNext == S_PIX);
         done <= (stateNext == S_FIN);
         err  <= rejectFill;
         if (state == S_INIT_FETCH && stateNext == S_FIN) init_ok <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start_init) begin
                  romAddr <= 8'd0;
                  romWait <= 1'b1;
               end else if (acceptFill) begin
                  x0     <= fill_x0;
                  x1     <= fill_x1;
                  y0     <= fill_y0;
                  y1     <= fill_y1;
                  color  <= fill_color;
                  pixCnt <= pixTotal;
                  seqIdx <= 4'd1;
               end
            end
            S_INIT_FETCH: begin
               if (romWait) begin
                  romWait <= 1'b0;
               end else if (byteFree) begin
                  romAddr <= romAddr + 8'd1;
                  romWait <= 1'b1;
                  if (romEntry.kind == ENT_DLY)
                     delayCnt <= DLY_W'(romEntry.val) * DLY_W'(DELAY_TICKS);
               end
            end
            S_INIT_DELAY: delayCnt <= delayCnt - DLY_W'(1);
            S_WIN: begin
               if (startByte) seqIdx <= seqIdx + 4'd1;
               if (stateNext == S_PIX) sentHi <= 1'b1;
            end
            S_PIX: begin
               if (lastByteCycle) begin
                  if (sentHi) begin
                     sentHi <= 1'b0;
                  end else begin
                     pixCnt <= pixCnt - PIX_W'(1);
                     sentHi <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer: init script, fills, rejects, priority,
// back-to-back requests and reset in the middle of a fill.
module tb_lcd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_init = 1'b0;
   logic       fill_req = 1'b0;
   logic [8:0] fill_x0 = '0, fill_x1 = '0, fill_y0 = '0, fill_y1 = '0;
   logic [15:0] fill_color = '0;
   logic       busy, done, err, init_ok, wrEn;
   logic [7:0] commData;
   logic [2:0] commAddr;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int errSeen = 0;
   logic prevWr = 1'b0;
   logic [2:0] addrQ[$];
   logic [7:0] dataQ[$];
   int riseQ[$];
   int fallQ[$];

   logic [2:0] fillAddr [19] = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2,
                                 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
   logic [7:0] fillData [19] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00,
                                 8'h00, 8'h01, 8'h2C, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8,
                                 8'h00, 8'hF8, 8'h00};

   lcd_sequencer #(
      .COORD_W     (9),
      .WR_HI       (2),
      .WR_LO       (2),
      .DELAY_TICKS (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_init (start_init),
      .fill_req   (fill_req),
      .fill_x0    (fill_x0),
      .fill_x1    (fill_x1),
      .fill_y0    (fill_y0),
      .fill_y1    (fill_y1),
      .fill_color (fill_color),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .init_ok    (init_ok),
      .commData   (commData),
      .commAddr   (commAddr),
      .wrEn       (wrEn)
   );

   always #5 clk = ~clk;

   // Byte log: every wrEn rise records the bus, every fall its cycle.
   always @(negedge clk) begin
      if (wrEn === 1'b1 && prevWr !== 1'b1) begin
         addrQ.push_back(commAddr);
         dataQ.push_back(commData);
         riseQ.push_back(cyc);
      end
      if (wrEn === 1'b0 && prevWr === 1'b1) fallQ.push_back(cyc);
      if (err === 1'b1) errSeen++;
      prevWr = wrEn;
      cyc++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clearLog();
      addrQ.delete();
      dataQ.delete();
      riseQ.delete();
      fallQ.delete();
   endtask

   task automatic pulseFill(input logic [8:0] ax0, input logic [8:0] ax1,
                            input logic [8:0] ay0, input logic [8:0] ay1,
                            input logic [15:0] col);
      @(posedge clk); #1;
      fill_x0 = ax0; fill_x1 = ax1; fill_y0 = ay0; fill_y1 = ay1;
      fill_color = col; fill_req = 1'b1;
      @(posedge clk); #1;
      fill_req = 1'b0;
   endtask

   task automatic pulseInit();
      @(posedge clk); #1 start_init = 1'b1;
      @(posedge clk); #1 start_init = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int busyCyc, output bit seen);
      busyCyc = 0;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) busyCyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (wrEn !== 1'b0) begin mismatched++; $display("FAIL reset_wrEn: got %b expected 0", wrEn); end
      compared++;
      if (commAddr !== 3'd0 || commData !== 8'h00) begin
         mismatched++; $display("FAIL reset_bus: got addr %0d data %h expected 0/00", commAddr, commData);
      end
      compared++;
      if ({busy, done, err, init_ok} !== 4'b0000) begin
         mismatched++; $display("FAIL reset_status: got busy/done/err/init_ok %b expected 0000", {busy, done, err, init_ok});
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_fill_before_init();
      int errBefore;
      clearLog();
      errBefore = errSeen;
      pulseFill(9'd0, 9'd1, 9'd0, 9'd1, 16'hF800);
      @(negedge clk);
      compared++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         mismatched++; $display("FAIL noinit_err: got err %b busy %b expected 1/0", err, busy);
      end
      @(negedge clk);
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL noinit_err_width: got err %b expected 0", err); end
      repeat (10) @(negedge clk);
      compared++;
      if (addrQ.size() != 0) begin mismatched++; $display("FAIL noinit_wr: got %0d bytes expected 0", addrQ.size()); end
      compared++;
      if (init_ok !== 1'b0 || errSeen - errBefore != 1) begin
         mismatched++; $display("FAIL noinit_state: got init_ok %b err cycles %0d expected 0/1", init_ok, errSeen - errBefore);
      end
   endtask

   task automatic test_init();
      int b;
      bit seen;
      clearLog();
      pulseInit();
      waitDone(400, b, seen);
      compared++;
      if (seen !== 1'b1 || busy !== 1'b0) begin
         mismatched++; $display("FAIL init_done: got seen %b busy %b expected 1/0", seen, busy);
      end
      compared++;
      if (init_ok !== 1'b1) begin mismatched++; $display("FAIL init_ok: got %b expected 1", init_ok); end
      compared++;
      if (addrQ.size() != 2) begin mismatched++; $display("FAIL init_count: got %0d bytes expected 2", addrQ.size()); end
      if (addrQ.size() >= 2 && fallQ.size() >= 1) begin
         compared++;
         if (addrQ[0] !== 3'd3 || dataQ[0] !== 8'h01) begin
            mismatched++; $display("FAIL init_byte0: got %0d/%h expected 3/01", addrQ[0], dataQ[0]);
         end
         compared++;
         if (addrQ[1] !== 3'd2 || dataQ[1] !== 8'h55) begin
            mismatched++; $display("FAIL init_byte1: got %0d/%h expected 2/55", addrQ[1], dataQ[1]);
         end
         compared++;
         if (riseQ[1] - fallQ[0] < 20) begin
            mismatched++; $display("FAIL init_delay: got %0d quiet cycles expected at least 20", riseQ[1] - fallQ[0]);
         end
      end
   endtask

   task automatic test_fill_basic();
      int b;
      bit seen;
      clearLog();
      pulseFill(9'd0, 9'd1, 9'd0, 9'd1, 16'hF800);
      @(negedge clk);
      compared++;
      if (wrEn !== 1'b1 || busy !== 1'b1) begin
         mismatched++; $display("FAIL fill_latency: got wrEn %b busy %b expected 1/1", wrEn, busy);
      end
      waitDone(400, b, seen);
      compared++;
      if (seen !== 1'b1 || b + 1 != 76) begin
         mismatched++; $display("FAIL fill_busy: got done %b busy cycles %0d expected 1/76", seen, b + 1);
      end
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("FAIL fill_fin_busy: got %b expected 0", busy); end
      compared++;
      if (addrQ.size() != 19) begin mismatched++; $display("FAIL fill_count: got %0d bytes expected 19", addrQ.size()); end
      for (int i = 0; i < 19 && i < addrQ.size(); i++) begin
         compared++;
         if ({addrQ[i], dataQ[i]} !== {fillAddr[i], fillData[i]}) begin
            mismatched++;
            $display("FAIL fill_byte%0d: got %0d/%h expected %0d/%h", i, addrQ[i], dataQ[i], fillAddr[i], fillData[i]);
         end
      end
      if (riseQ.size() >= 2 && fallQ.size() >= 1) begin
         compared++;
         if (fallQ[0] - riseQ[0] != 2 || riseQ[1] - riseQ[0] != 4) begin
            mismatched++; $display("FAIL fill_strobe: got high %0d period %0d expected 2/4", fallQ[0] - riseQ[0], riseQ[1] - riseQ[0]);
         end
      end
   endtask

   task automatic test_bad_rect();
      int errBefore;
      clearLog();
      errBefore = errSeen;
      pulseFill(9'd5, 9'd4, 9'd0, 9'd0, 16'h07E0);
      @(negedge clk);
      compared++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         mismatched++; $display("FAIL badrect_err: got err %b busy %b expected 1/0", err, busy);
      end
      repeat (20) @(negedge clk);
      compared++;
      if (addrQ.size() != 0 || errSeen - errBefore != 1) begin
         mismatched++; $display("FAIL badrect_quiet: got %0d bytes %0d err cycles expected 0/1", addrQ.size(), errSeen - errBefore);
      end
   endtask

   task automatic test_priority();
      int b;
      int errBefore;
      bit seen;
      clearLog();
      errBefore = errSeen;
      @(posedge clk); #1;
      fill_x0 = 9'd0; fill_x1 = 9'd0; fill_y0 = 9'd0; fill_y1 = 9'd0; fill_color = 16'hFFFF;
      start_init = 1'b1; fill_req = 1'b1;
      @(posedge clk); #1;
      start_init = 1'b0; fill_req = 1'b0;
      waitDone(400, b, seen);
      compared++;
      if (seen !== 1'b1) begin mismatched++; $display("FAIL prio_done: got %b expected 1", seen); end
      repeat (20) @(negedge clk);
      compared++;
      if (addrQ.size() != 2 || errSeen != errBefore) begin
         mismatched++; $display("FAIL prio_count: got %0d bytes %0d err cycles expected 2/0", addrQ.size(), errSeen - errBefore);
      end
      if (addrQ.size() >= 1) begin
         compared++;
         if (addrQ[0] !== 3'd3 || dataQ[0] !== 8'h01) begin
            mismatched++; $display("FAIL prio_first: got %0d/%h expected 3/01", addrQ[0], dataQ[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int b1, b2;
      int errBefore;
      bit s1, s2;
      clearLog();
      errBefore = errSeen;
      @(posedge clk); #1;
      fill_x0 = 9'd3; fill_x1 = 9'd3; fill_y0 = 9'd3; fill_y1 = 9'd3; fill_color = 16'h1234;
      fill_req = 1'b1;
      waitDone(400, b1, s1);
      waitDone(400, b2, s2);
      fill_req = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (s1 !== 1'b1 || s2 !== 1'b1 || b1 != 52 || b2 != 52) begin
         mismatched++; $display("FAIL b2b_busy: got done %b%b busy %0d/%0d expected 11 52/52", s1, s2, b1, b2);
      end
      compared++;
      if (addrQ.size() != 26 || errSeen != errBefore) begin
         mismatched++; $display("FAIL b2b_count: got %0d bytes %0d err cycles expected 26/0", addrQ.size(), errSeen - errBefore);
      end
      if (addrQ.size() >= 26) begin
         compared++;
         if (addrQ[2] !== 3'd2 || dataQ[2] !== 8'h03) begin
            mismatched++; $display("FAIL b2b_x0lo: got %0d/%h expected 2/03", addrQ[2], dataQ[2]);
         end
         compared++;
         if (addrQ[13] !== 3'd3 || dataQ[13] !== 8'h2A) begin
            mismatched++; $display("FAIL b2b_second: got %0d/%h expected 3/2A", addrQ[13], dataQ[13]);
         end
         compared++;
         if ({dataQ[24], dataQ[25]} !== 16'h1234 || addrQ[25] !== 3'd2) begin
            mismatched++; $display("FAIL b2b_pixel: got %h%h addr %0d expected 1234 addr 2", dataQ[24], dataQ[25], addrQ[25]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit reached;
      clearLog();
      reached = 1'b0;
      pulseFill(9'd0, 9'd1, 9'd0, 9'd1, 16'hF800);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (addrQ.size() >= 16) begin
            reached = 1'b1;
            break;
         end
      end
      compared++;
      if (reached !== 1'b1 || dataQ[15] !== 8'hF8 || addrQ[15] !== 3'd2) begin
         mismatched++; $display("FAIL rstmid_reach: got reached %b bytes %0d expected 1 with 3rd pixel hi", reached, addrQ.size());
      end
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      compared++;
      if (wrEn !== 1'b0 || busy !== 1'b0 || init_ok !== 1'b0) begin
         mismatched++; $display("FAIL rstmid_state: got wrEn %b busy %b init_ok %b expected 0/0/0", wrEn, busy, init_ok);
      end
      compared++;
      if (commAddr !== 3'd0) begin mismatched++; $display("FAIL rstmid_addr: got %0d expected 0", commAddr); end
      n = addrQ.size();
      repeat (20) @(negedge clk);
      compared++;
      if (addrQ.size() != n || busy !== 1'b0) begin
         mismatched++; $display("FAIL rstmid_idle: got %0d new bytes busy %b expected 0/0", addrQ.size() - n, busy);
      end
   endtask

   initial begin
      test_reset();
      test_fill_before_init();
      test_init();
      test_fill_basic();
      test_bad_rect();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Command sequencer for the 8-bit parallel LCD write path. It drives the display interface's `commData`/`commAddr`/`wrEn` inputs. It runs the power-on initialisation script from a small ROM, then serves host window-fill requests: it sets the column and page window, issues memory-write, and streams one 16-bit colour for every pixel in the rectangle. It is the only master of the display interface.

## Interface
Parameters:
- `COORD_W`, 9: coordinate width in pixels.
- `WR_HI`, 2: cycles `wrEn` is held high per byte (≥1).
- `WR_LO`, 2: cycles `wrEn` is held low after each byte (≥2; covers the interface's CS release).
- `DELAY_TICKS`, 50000: clocks per init-script delay unit.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `start_init` in 1: level sampled in IDLE; starts the init script.
- `fill_req` in 1: level sampled in IDLE; starts a window fill.
- `fill_x0`, `fill_x1`, `fill_y0`, `fill_y1` in COORD_W each: inclusive rectangle corners, captured on accept.
- `fill_color` in 16: RGB565 colour, captured on accept.
- `busy` out 1: high while a script or fill is in progress.
- `done` out 1: one-cycle pulse when a script or fill completes.
- `err` out 1: one-cycle pulse when a request is rejected.
- `init_ok` out 1: set when the init script completes; cleared only by `rst`.
- `commData` out 8: byte to transfer.
- `commAddr` out 3: 3 = command byte (RS low), 2 = data byte. 0 is driven when idle.
- `wrEn` out 1: write strobe to the display interface.

## Operation
- Reset values: `wrEn`=0, `commAddr`=0, `commData`=0, `busy`=0, `done`=0, `err`=0, `init_ok`=0, FSM=IDLE.
- States: IDLE, INIT_FETCH, INIT_DELAY, WIN, PIX, FIN.
- Byte engine (shared by all states):
  - `commAddr`/`commData` are loaded on the same edge that raises `wrEn`.
  - They stay stable for all WR_HI + WR_LO cycles.
  - `wrEn` is high for WR_HI cycles, then low for WR_LO cycles.
  - The next byte may start only after the low phase completes.
- IDLE transitions:
  - `start_init`=1 → INIT_FETCH. `start_init` has priority over `fill_req`.
  - `fill_req`=1 with `init_ok`=0 → `err` pulse, stay IDLE.
  - `fill_req`=1 with `x1<x0` or `y1<y0` → `err` pulse, stay IDLE.
  - Otherwise `fill_req`=1 → capture the fill operands, go to WIN.
  - Requests arriving while `busy`=1 are ignored; no error is flagged.
- INIT_FETCH reads a ROM entry {type[1:0], val[7:0]}:
  - CMD: send `val` with `commAddr`=3.
  - DAT: send `val` with `commAddr`=2.
  - DLY: go to INIT_DELAY for `val`×DELAY_TICKS cycles with `wrEn`=0, then fetch the next entry.
  - END: set `init_ok` → FIN.
- WIN sends 11 bytes in this order:
  - 0x2A(cmd), x0[15:8], x0[7:0], x1[15:8], x1[7:0]
  - 0x2B(cmd), y0 hi, y0 lo, y1 hi, y1 lo
  - 0x2C(cmd)
  - Coordinate bytes are data bytes and are zero-extended to 16 bits.
  - After the last byte → PIX.
- PIX:
  - Pixel count N = (x1−x0+1)·(y1−y0+1), computed as a 2·COORD_W+1-bit product that cannot overflow.
  - For each pixel, send `fill_color[15:8]` then `fill_color[7:0]`, both as data bytes.
  - Decrement the pixel counter after the low byte; at zero → FIN.
- FIN: pulse `done`, drop `busy` → IDLE.
- `rst` asserted mid-transfer: on the next edge `wrEn`=0, FSM=IDLE and `init_ok`=0. The interrupted byte is abandoned.

## Timing
- Request sampled in IDLE at edge k: `busy`=1 from k+1, first `wrEn` rise at k+1.
- Byte period = WR_HI+WR_LO clocks. There is no idle gap between consecutive bytes.
- Fill duration = (11+2N)·(WR_HI+WR_LO) clocks, followed by one FIN cycle.
- In FIN, `done`=1 and `busy`=0 in the same cycle. The first cycle back in IDLE can accept a new request.
- An `err` pulse comes 1 cycle after the sampling edge; `busy` stays 0.

## Structure
- Package `lcd_pkg`:
  - Entry type codes CMD/DAT/DLY/END.
  - Opcodes 0x2A/0x2B/0x2C.
  - `commAddr` constants 2/3.
  - FSM state enum.
- Sub-module `lcd_init_rom`: synchronous read with one-cycle latency, indexed by an 8-bit address. INIT_FETCH waits that one cycle before using the entry.
- The byte engine lives inline in `lcd_sequencer`.

## Test plan
- Reset, then `fill_req` → `err`=1 for one cycle, `wrEn` never rises, `init_ok`=0.
- Test ROM {CMD 0x01, DLY 2, DAT 0x55, END}, DELAY_TICKS=10, `start_init` →
  - `commAddr`=3 / `commData`=0x01;
  - 20 quiet cycles;
  - `commAddr`=2 / `commData`=0x55;
  - `done`, `init_ok`=1.
- Fill (0,0)–(1,1) with 0xF800, WR_HI=WR_LO=2 →
  - bytes 2A 00 00 00 01 2B 00 00 00 01 2C, then F8 00 repeated four times;
  - 76 busy cycles, then `done`.
- Fill with x0=5, x1=4 → `err` pulse, no `wrEn` activity.
- `start_init` and `fill_req` raised in the same cycle → init runs; the fill is not accepted.
- `rst` during the 3rd pixel → `wrEn`=0 next cycle, `busy`=0, `init_ok`=0.
